// File: rtl/nc_icache_line_buffer_pkg.sv
// Shared types for the non-cacheable instruction fetch line buffer: fetch/response
// structs, FSM state encoding, default address windows and line offset helper.
package nc_icache_line_buffer_pkg;

  localparam int VADDR_W = 40;

  localparam logic [VADDR_W-1:0] DRAM_BASE_DEF = 40'h00_8000_0000;
  localparam logic [VADDR_W-1:0] DRAM_END_DEF  = 40'h00_C000_0000;
  localparam logic [VADDR_W-1:0] EXE_BASE_DEF  = 40'h00_0001_0000;
  localparam logic [VADDR_W-1:0] EXE_END_DEF   = 40'h00_0002_0000;

  typedef enum logic [1:0] {
    NC_IDLE,
    NC_WAIT,
    NC_KILL
  } nc_state_t;

  typedef struct packed {
    logic               valid;
    logic [VADDR_W-1:0] vaddr;
    logic               invalidate_icache;
    logic               invalidate_buffer;
    logic               inval_fetch;
  } req_cpu_icache_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        instr_page_fault;
  } resp_icache_cpu_t;

  // Byte-offset bits of one L2 line.
  function automatic int off_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/nc_icache_line_buffer_entry_array.sv
// Fully associative line store for NC fetches: tag CAM, line data, valid bits,
// victim selection (first free entry, else round-robin) and whole-buffer flush.
module nc_ibuf_entry_array #(
  parameter int NC_ENTRIES = 4,
  parameter int TAG_W      = 35,
  parameter int LINE_W     = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [LINE_W-1:0] hit_line_o,
  input  logic              wr_en_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_line_i
);

  localparam int PTR_W = (NC_ENTRIES > 1) ? $clog2(NC_ENTRIES) : 1;

  logic [NC_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]      r_tag  [NC_ENTRIES];
  logic [LINE_W-1:0]     r_line [NC_ENTRIES];
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      w_victim;
  logic                  w_have_free;
  logic                  w_write;

  assign w_write = wr_en_i & ~flush_i;

  always_comb begin
    hit_o      = 1'b0;
    hit_line_o = '0;
    for (int i = 0; i < NC_ENTRIES; i++) begin
      if (r_valid[i] && (r_tag[i] == lookup_tag_i)) begin
        hit_o      = 1'b1;
        hit_line_o = r_line[i];
      end
    end
  end

  // Scan downwards so the lowest-index free entry is the one left standing.
  always_comb begin
    w_victim    = r_rr_ptr;
    w_have_free = 1'b0;
    for (int i = NC_ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_have_free = 1'b1;
        w_victim    = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid  <= '0;
      r_rr_ptr <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (w_write) begin
      r_valid[w_victim] <= 1'b1;
      if (!w_have_free) begin
        if (r_rr_ptr == PTR_W'(NC_ENTRIES - 1)) r_rr_ptr <= '0;
        else                                    r_rr_ptr <= r_rr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_write && !rst_i) begin
      r_tag[w_victim]  <= wr_tag_i;
      r_line[w_victim] <= wr_line_i;
    end
  end

endmodule

// File: rtl/nc_icache_line_buffer.sv
// NC instruction fetch bypass: classifies fetches, serves NC fetches from a small
// line buffer and issues one outstanding L2 line request on a miss.
//
// state | meaning
// IDLE  | accepting fetches, S2 lookup active, miss issues L2 request
// WAIT  | L2 line request outstanding, fill + respond on grant
// KILL  | request outstanding but fetch was killed, drop the grant
module nc_icache_line_buffer
  import nc_icache_line_buffer_pkg::*;
#(
  parameter int                 NC_ENTRIES = 4,
  parameter int                 LINE_W     = 256,
  parameter int                 PADDR_W    = 40,
  parameter logic [PADDR_W-1:0] DRAM_BASE  = PADDR_W'(DRAM_BASE_DEF),
  parameter logic [PADDR_W-1:0] DRAM_END   = PADDR_W'(DRAM_END_DEF),
  parameter logic [PADDR_W-1:0] EXE_BASE   = PADDR_W'(EXE_BASE_DEF),
  parameter logic [PADDR_W-1:0] EXE_END    = PADDR_W'(EXE_END_DEF)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_translation_i,
  input  logic               req_icache_ready_i,
  input  logic               l2_grant_valid_i,
  input  logic [LINE_W-1:0]  l2_resp_data_i,
  input  req_cpu_icache_t    datapath_req_i,
  input  resp_icache_cpu_t   icache_resp_i,
  output logic               req_nc_valid_o,
  output logic [PADDR_W-1:0] req_nc_paddr_o,
  output logic               req_icache_ready_o,
  output req_cpu_icache_t    req_icache_o,
  output resp_icache_cpu_t   resp_datapath_o
);

  localparam int OFF   = off_bits(LINE_W);
  localparam int TAG_W = PADDR_W - OFF;

  nc_state_t          r_state;
  logic               r_s1_valid;
  logic [PADDR_W-1:2] r_s1_addr;
  logic [PADDR_W-1:2] r_miss_addr;
  logic               r_fill_resp_valid;
  logic [31:0]        r_fill_resp_data;

  logic [PADDR_W-1:0] w_addr;
  logic               w_kill, w_cacheable, w_in_exe, w_nc_exe;
  logic               w_s2_valid, w_s2_hit, w_s2_miss, w_accept, w_grant_fill;
  logic               w_nc_resp_valid, w_arr_hit;
  logic [LINE_W-1:0]  w_arr_line;
  logic [31:0]        w_hit_word, w_fill_word;
  logic [TAG_W-1:0]   w_s2_tag, w_miss_tag;

  assign w_addr      = datapath_req_i.vaddr[PADDR_W-1:0];
  assign w_kill      = datapath_req_i.inval_fetch | datapath_req_i.invalidate_icache
                     | datapath_req_i.invalidate_buffer;
  assign w_cacheable = en_translation_i | ((w_addr >= DRAM_BASE) && (w_addr < DRAM_END));
  assign w_in_exe    = (w_addr >= EXE_BASE) && (w_addr < EXE_END);
  assign w_nc_exe    = ~w_cacheable & w_in_exe;

  assign w_s2_tag   = r_s1_addr[PADDR_W-1:OFF];
  assign w_miss_tag = r_miss_addr[PADDR_W-1:OFF];
  assign w_s2_valid = r_s1_valid & ~w_kill & (r_state == NC_IDLE);
  assign w_s2_hit   = w_s2_valid & w_arr_hit;
  assign w_s2_miss  = w_s2_valid & ~w_arr_hit;

  assign req_icache_ready_o = req_icache_ready_i & (r_state == NC_IDLE) & ~w_s2_miss;
  assign w_accept           = datapath_req_i.valid & req_icache_ready_o & w_nc_exe & ~w_kill;
  assign w_grant_fill       = (r_state == NC_WAIT) & l2_grant_valid_i & ~w_kill;

  assign req_nc_valid_o = w_s2_miss;
  assign req_nc_paddr_o = {w_s2_tag, {OFF{1'b0}}};

  assign w_hit_word  = w_arr_line[{r_s1_addr[OFF-1:2], 5'b0} +: 32];
  assign w_fill_word = l2_resp_data_i[{r_miss_addr[OFF-1:2], 5'b0} +: 32];

  nc_ibuf_entry_array #(
    .NC_ENTRIES (NC_ENTRIES),
    .TAG_W      (TAG_W),
    .LINE_W     (LINE_W)
  ) u_entries (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (w_kill),
    .lookup_tag_i (w_s2_tag),
    .hit_o        (w_arr_hit),
    .hit_line_o   (w_arr_line),
    .wr_en_i      (w_grant_fill),
    .wr_tag_i     (w_miss_tag),
    .wr_line_i    (l2_resp_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state           <= NC_IDLE;
      r_s1_valid        <= 1'b0;
      r_s1_addr         <= '0;
      r_miss_addr       <= '0;
      r_fill_resp_valid <= 1'b0;
      r_fill_resp_data  <= '0;
    end else begin
      r_s1_valid        <= w_accept;
      r_fill_resp_valid <= w_grant_fill;
      if (w_accept)     r_s1_addr        <= w_addr[PADDR_W-1:2];
      if (w_grant_fill) r_fill_resp_data <= w_fill_word;
      case (r_state)
        NC_IDLE: begin
          if (w_s2_miss) begin
            r_miss_addr <= r_s1_addr;
            r_state     <= NC_WAIT;
          end
        end
        NC_WAIT: begin
          if (l2_grant_valid_i) r_state <= NC_IDLE;
          else if (w_kill)      r_state <= NC_KILL;
        end
        NC_KILL: begin
          if (l2_grant_valid_i) r_state <= NC_IDLE;
        end
        default: r_state <= NC_IDLE;
      endcase
    end
  end

  // A kill also squashes a fill response that is about to be presented.
  assign w_nc_resp_valid = (w_s2_hit | r_fill_resp_valid) & ~w_kill;

  always_comb begin
    req_icache_o       = datapath_req_i;
    req_icache_o.valid = datapath_req_i.valid & w_cacheable;
  end

  always_comb begin
    resp_datapath_o = icache_resp_i;
    if (w_nc_resp_valid) begin
      resp_datapath_o.valid            = 1'b1;
      resp_datapath_o.data             = w_s2_hit ? w_hit_word : r_fill_resp_data;
      resp_datapath_o.instr_page_fault = 1'b0;
    end
  end

endmodule

// File: tb/tb_nc_icache_line_buffer.sv
// Self-checking bench for nc_icache_line_buffer: scoreboard queues for L2 requests
// and NC responses plus per-scenario timing checks.
module tb_nc_icache_line_buffer;
  import nc_icache_line_buffer_pkg::*;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             en_translation;
  logic             ready_in;
  logic             l2_grant;
  logic [255:0]     l2_data;
  req_cpu_icache_t  dp_req;
  req_cpu_icache_t  ic_req;
  resp_icache_cpu_t ic_resp;
  resp_icache_cpu_t dp_resp;
  logic             req_nc_valid;
  logic [39:0]      req_nc_paddr;
  logic             ready_out;

  int checks = 0;
  int errors = 0;

  logic [39:0]  exp_req_q[$];
  logic [31:0]  exp_resp_q[$];
  logic [39:0]  e_addr;
  logic [31:0]  e_data;
  logic [255:0] line0;

  always #5 clk = ~clk;

  nc_icache_line_buffer #(
    .NC_ENTRIES (4),
    .LINE_W     (256),
    .PADDR_W    (40),
    .DRAM_BASE  (40'h00_8000_0000),
    .DRAM_END   (40'h00_C000_0000),
    .EXE_BASE   (40'h00_0001_0000),
    .EXE_END    (40'h00_0002_0000)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .en_translation_i   (en_translation),
    .req_icache_ready_i (ready_in),
    .l2_grant_valid_i   (l2_grant),
    .l2_resp_data_i     (l2_data),
    .datapath_req_i     (dp_req),
    .icache_resp_i      (ic_resp),
    .req_nc_valid_o     (req_nc_valid),
    .req_nc_paddr_o     (req_nc_paddr),
    .req_icache_ready_o (ready_out),
    .req_icache_o       (ic_req),
    .resp_datapath_o    (dp_resp)
  );

  function automatic logic [255:0] mk_line(input logic [39:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[15:0], 8'hC3, i[7:0]};
    return l;
  endfunction

  function automatic logic [31:0] word_of(input logic [255:0] l, input logic [39:0] a);
    int w;
    w = int'(a[4:2]);
    return l[w*32 +: 32];
  endfunction

  task automatic start_fetch(input logic [39:0] a);
    @(posedge clk); #1;
    dp_req.valid = 1'b1;
    dp_req.vaddr = a;
  endtask

  task automatic end_fetch();
    @(posedge clk); #1;
    dp_req.valid = 1'b0;
  endtask

  // Fetch that must miss; the grant follows one cycle after the request.
  task automatic miss_fill(input logic [39:0] a, input logic [255:0] l);
    exp_req_q.push_back({a[39:5], 5'b0});
    start_fetch(a);
    end_fetch();
    @(posedge clk); #1;
    l2_grant = 1'b1;
    l2_data  = l;
    exp_resp_q.push_back(word_of(l, a));
    @(posedge clk); #1;
    l2_grant = 1'b0;
    @(negedge clk);
  endtask

  task automatic hit_fetch(input logic [39:0] a, input logic [255:0] l);
    exp_resp_q.push_back(word_of(l, a));
    start_fetch(a);
    end_fetch();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (req_nc_valid !== 1'b0 || dp_resp.valid !== 1'b0 || ic_req.valid !== 1'b0 || req_nc_paddr !== 40'h0) begin
      errors++;
      $display("FAIL reset_outputs: got nc_valid=%b resp_valid=%b ic_valid=%b paddr=%h, expected all zero",
               req_nc_valid, dp_resp.valid, ic_req.valid, req_nc_paddr);
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", ready_out);
    end
  endtask

  task automatic test_nc_miss();
    line0 = mk_line(40'h1_0040);
    line0[32 +: 32] = 32'hDEAD_BEEF;
    exp_req_q.push_back(40'h1_0040);
    start_fetch(40'h1_0044);
    @(negedge clk);
    checks++;
    if (ic_req.valid !== 1'b0) begin
      errors++;
      $display("FAIL nc_not_to_icache: got %b expected 0", ic_req.valid);
    end
    end_fetch();
    @(negedge clk);
    checks++;
    if (req_nc_valid !== 1'b1 || req_nc_paddr !== 40'h1_0040 || ready_out !== 1'b0) begin
      errors++;
      $display("FAIL miss_request: got valid=%b paddr=%h ready=%b expected 1 0000010040 0",
               req_nc_valid, req_nc_paddr, ready_out);
    end
    @(posedge clk); #1;
    l2_grant = 1'b1;
    l2_data  = line0;
    exp_resp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    checks++;
    if (req_nc_valid !== 1'b0 || dp_resp.valid !== 1'b0) begin
      errors++;
      $display("FAIL grant_cycle: got nc_valid=%b resp_valid=%b expected 0 0", req_nc_valid, dp_resp.valid);
    end
    @(posedge clk); #1;
    l2_grant = 1'b0;
    @(negedge clk);
    checks++;
    if (dp_resp.valid !== 1'b1 || dp_resp.data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL fill_response: got valid=%b data=%h expected 1 deadbeef", dp_resp.valid, dp_resp.data);
    end
  endtask

  task automatic test_hit();
    exp_resp_q.push_back(line0[7*32 +: 32]);
    start_fetch(40'h1_005C);
    end_fetch();
    @(negedge clk);
    checks++;
    if (dp_resp.valid !== 1'b1 || req_nc_valid !== 1'b0 || dp_resp.data !== line0[7*32 +: 32]) begin
      errors++;
      $display("FAIL hit_response: got valid=%b nc_req=%b data=%h expected 1 0 %h",
               dp_resp.valid, req_nc_valid, dp_resp.data, line0[7*32 +: 32]);
    end
    @(negedge clk);
    checks++;
    if (dp_resp.valid !== 1'b0) begin
      errors++;
      $display("FAIL hit_single_cycle: got %b expected 0", dp_resp.valid);
    end
  endtask

  task automatic test_rr_evict();
    @(posedge clk); #1 dp_req.invalidate_buffer = 1'b1;
    @(posedge clk); #1 dp_req.invalidate_buffer = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [39:0] a;
      a = 40'h1_0000 + 40'(i * 32);
      miss_fill(a, mk_line(a));
    end
    hit_fetch(40'h1_0024, mk_line(40'h1_0020));
    miss_fill(40'h1_0000, mk_line(40'h1_0000));
    miss_fill(40'h1_0028, mk_line(40'h1_0020));
    hit_fetch(40'h1_0060, mk_line(40'h1_0060));
    hit_fetch(40'h1_009C, mk_line(40'h1_0080));
    checks++;
    if (exp_req_q.size() !== 0 || exp_resp_q.size() !== 0) begin
      errors++;
      $display("FAIL rr_evict_pending: got req_q=%0d resp_q=%0d expected 0 0", exp_req_q.size(), exp_resp_q.size());
    end
  endtask

  task automatic test_kill_in_wait();
    exp_req_q.push_back(40'h1_0040);
    start_fetch(40'h1_0044);
    end_fetch();
    @(posedge clk); #1 dp_req.inval_fetch = 1'b1;
    @(posedge clk); #1 dp_req.inval_fetch = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL kill_state_busy: got ready=%b expected 0", ready_out);
    end
    @(posedge clk);
    @(posedge clk); #1;
    l2_grant = 1'b1;
    l2_data  = mk_line(40'h1_0040);
    @(posedge clk); #1 l2_grant = 1'b0;
    @(negedge clk);
    checks++;
    if (dp_resp.valid !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL kill_discard: got resp_valid=%b ready=%b expected 0 1", dp_resp.valid, ready_out);
    end
    miss_fill(40'h1_0044, mk_line(40'h1_0040));
    miss_fill(40'h1_0064, mk_line(40'h1_0060));
    checks++;
    if (exp_req_q.size() !== 0) begin
      errors++;
      $display("FAIL kill_refetch_miss: got %0d pending requests expected 0", exp_req_q.size());
    end
  endtask

  task automatic test_grant_kill_same();
    exp_req_q.push_back(40'h1_00A0);
    start_fetch(40'h1_00A4);
    end_fetch();
    @(posedge clk); #1;
    l2_grant = 1'b1;
    l2_data  = mk_line(40'h1_00A0);
    dp_req.invalidate_icache = 1'b1;
    @(posedge clk); #1;
    l2_grant = 1'b0;
    dp_req.invalidate_icache = 1'b0;
    @(negedge clk);
    checks++;
    if (dp_resp.valid !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL grant_kill_same: got resp_valid=%b ready=%b expected 0 1", dp_resp.valid, ready_out);
    end
    @(posedge clk); #1 l2_grant = 1'b1;
    @(posedge clk); #1 l2_grant = 1'b0;
    @(negedge clk);
    checks++;
    if (dp_resp.valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_grant_ignored: got resp_valid=%b expected 0", dp_resp.valid);
    end
    miss_fill(40'h1_00A4, mk_line(40'h1_00A0));
  endtask

  task automatic test_passthrough();
    start_fetch(40'h00_8000_0000);
    @(negedge clk);
    checks++;
    if (ic_req.valid !== 1'b1 || ic_req.vaddr !== 40'h00_8000_0000) begin
      errors++;
      $display("FAIL dram_passthrough: got valid=%b vaddr=%h expected 1 0080000000", ic_req.valid, ic_req.vaddr);
    end
    end_fetch();
    en_translation = 1'b1;
    start_fetch(40'h1_0044);
    @(negedge clk);
    checks++;
    if (ic_req.valid !== 1'b1) begin
      errors++;
      $display("FAIL translation_passthrough: got %b expected 1", ic_req.valid);
    end
    end_fetch();
    @(negedge clk);
    checks++;
    if (req_nc_valid !== 1'b0 || dp_resp.valid !== 1'b0) begin
      errors++;
      $display("FAIL translation_no_nc: got nc=%b resp=%b expected 0 0", req_nc_valid, dp_resp.valid);
    end
    en_translation = 1'b0;
    start_fetch(40'h3_0000);
    @(negedge clk);
    checks++;
    if (ic_req.valid !== 1'b0) begin
      errors++;
      $display("FAIL dropped_no_icache: got %b expected 0", ic_req.valid);
    end
    end_fetch();
    @(negedge clk);
    checks++;
    if (req_nc_valid !== 1'b0 || dp_resp.valid !== 1'b0) begin
      errors++;
      $display("FAIL dropped_no_nc: got nc=%b resp=%b expected 0 0", req_nc_valid, dp_resp.valid);
    end
  endtask

  task automatic test_page_fault();
    resp_icache_cpu_t exp;
    exp = '{valid: 1'b1, data: 32'h1234_5678, instr_page_fault: 1'b1};
    @(posedge clk); #1 ic_resp = exp;
    @(negedge clk);
    checks++;
    if (dp_resp !== exp) begin
      errors++;
      $display("FAIL icache_resp_forward: got %h expected %h", dp_resp, exp);
    end
    @(posedge clk); #1 ic_resp = '0;
  endtask

  task automatic test_reset_in_wait();
    exp_req_q.push_back(40'h1_0040);
    start_fetch(40'h1_0044);
    end_fetch();
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    l2_grant = 1'b1;
    l2_data  = mk_line(40'h1_0040);
    @(posedge clk); #1 l2_grant = 1'b0;
    @(negedge clk);
    checks++;
    if (dp_resp.valid !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_wait: got resp_valid=%b ready=%b expected 0 1", dp_resp.valid, ready_out);
    end
    miss_fill(40'h1_00A8, mk_line(40'h1_00A0));
    miss_fill(40'h1_0064, mk_line(40'h1_0060));
  endtask

  task automatic test_drain();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_req_q.size() !== 0 || exp_resp_q.size() !== 0) begin
      errors++;
      $display("FAIL drain: got req_q=%0d resp_q=%0d expected 0 0", exp_req_q.size(), exp_resp_q.size());
    end
  endtask

  initial begin
    rst_i          = 1'b1;
    en_translation = 1'b0;
    ready_in       = 1'b1;
    l2_grant       = 1'b0;
    l2_data        = '0;
    dp_req         = '0;
    ic_resp        = '0;
    fork
      forever begin
        @(negedge clk);
        assert (!(ic_resp.valid && exp_resp_q.size() != 0))
          else $error("illegal overlap of nc and icache responses");
        if (!rst_i) begin
          if (dp_resp.valid && !ic_resp.valid) begin
            checks++;
            if (exp_resp_q.size() == 0) begin
              errors++;
              $display("FAIL sb_resp_unexpected: got data %h, expected no response", dp_resp.data);
            end else begin
              e_data = exp_resp_q.pop_front();
              if (dp_resp.data !== e_data || dp_resp.instr_page_fault !== 1'b0) begin
                errors++;
                $display("FAIL sb_resp: got data %h pf %b, expected %h pf 0",
                         dp_resp.data, dp_resp.instr_page_fault, e_data);
              end
            end
          end
          if (req_nc_valid) begin
            checks++;
            if (exp_req_q.size() == 0) begin
              errors++;
              $display("FAIL sb_req_unexpected: got paddr %h, expected no request", req_nc_paddr);
            end else begin
              e_addr = exp_req_q.pop_front();
              if (req_nc_paddr !== e_addr) begin
                errors++;
                $display("FAIL sb_req: got paddr %h expected %h", req_nc_paddr, e_addr);
              end
            end
          end
        end
      end
    join_none
    test_reset();
    test_nc_miss();
    test_hit();
    test_rr_evict();
    test_kill_in_wait();
    test_grant_kill_same();
    test_passthrough();
    test_page_fault();
    test_reset_in_wait();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
